// File: rtl/lane_pkg.sv
// Shared types, widths and the result saturation helper for the lane result filter.
package lane_pkg;

  localparam int unsigned RESULT_W = 48;
  localparam int unsigned STEER_W  = 16;

  typedef enum logic [1:0] {
    STRAIGHT = 2'b00,
    RIGHT    = 2'b01,
    LEFT     = 2'b10,
    RSVD     = 2'b11
  } dir_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_PRESENT
  } state_t;

  // Clamp an already-shifted result into the signed steering range.
  function automatic logic signed [STEER_W-1:0] sat_steer(input logic signed [RESULT_W-1:0] v);
    logic signed [RESULT_W-1:0] max_v;
    logic signed [RESULT_W-1:0] min_v;
    max_v = 48'sd32767;
    min_v = -48'sd32768;
    if (v > max_v)      return 16'sh7FFF;
    else if (v < min_v) return 16'sh8000;
    else                return v[STEER_W-1:0];
  endfunction

endpackage

// File: rtl/lane_result_filter_if.sv
// Result/command bus between the CNN producer, the filter and the steering consumer.
interface lane_result_filter_if;
  import lane_pkg::*;

  logic                i_result_valid;
  logic [RESULT_W-1:0] i_result_data;
  logic                i_clear;
  logic                o_cmd_valid;
  logic                i_cmd_ready;
  logic [STEER_W-1:0]  o_steer;
  logic [1:0]          o_dir;
  logic                o_overrun;
  logic                o_stale;

  // Filter side
  modport slave (
    input  i_result_valid, i_result_data, i_clear, i_cmd_ready,
    output o_cmd_valid, o_steer, o_dir, o_overrun, o_stale
  );

  // Producer/consumer side
  modport master (
    output i_result_valid, i_result_data, i_clear, i_cmd_ready,
    input  o_cmd_valid, o_steer, o_dir, o_overrun, o_stale
  );
endinterface

// File: rtl/lane_window_avg.sv
// Four-entry sliding window of steering samples with preload and floor average.
module lane_window_avg
  import lane_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr_en,
  input  logic                      clear,
  input  logic                      stale,
  input  logic signed [STEER_W-1:0] din,
  output logic signed [STEER_W-1:0] avg
);

  logic signed [STEER_W-1:0] win [4];
  logic                      filled;
  logic signed [STEER_W+1:0] sum;
  logic signed [STEER_W+1:0] sum_sh;

  // Window shift / preload and filled flag; a write marks the window filled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < 4; i++) win[i] <= '0;
      filled <= 1'b0;
    end else if (wr_en) begin
      if (!filled || stale) begin
        for (int unsigned i = 0; i < 4; i++) win[i] <= din;
      end else begin
        win[0] <= win[1];
        win[1] <= win[2];
        win[2] <= win[3];
        win[3] <= din;
      end
      filled <= 1'b1;
    end else if (clear) begin
      filled <= 1'b0;
    end
  end

  // 18-bit signed sum and floor divide by four.
  always_comb begin
    sum = '0;
    for (int unsigned i = 0; i < 4; i++) sum = sum + {{2{win[i][STEER_W-1]}}, win[i]};
    sum_sh = sum >>> 2;
    avg    = sum_sh[STEER_W-1:0];
  end

endmodule

// File: rtl/lane_result_filter.sv
// Edge-captures CNN lane results, scales/saturates them, averages over four samples
// and presents a steering command with a valid/ready handshake.
module lane_result_filter
  import lane_pkg::*;
#(
  parameter int          SHIFT    = 16,
  parameter int signed   DEADBAND = 256,
  parameter int unsigned TIMEOUT  = 60000
) (
  input logic clk,
  input logic rst,
  lane_result_filter_if.slave bus
);

  localparam logic [15:0]        TIMEOUT_C = 16'(TIMEOUT);
  localparam logic signed [17:0] DB        = 18'(DEADBAND);

  state_t                    state, state_nx;
  logic                      prev_valid;
  logic                      cap_q;
  logic signed [STEER_W-1:0] sample_q;
  logic signed [RESULT_W-1:0] shifted;
  logic                      accept;
  logic                      drop;
  logic signed [STEER_W-1:0] avg;
  logic signed [17:0]        avg_ext;
  dir_t                      dir_c;
  logic signed [STEER_W-1:0] steer_q;
  dir_t                      dir_q;
  logic                      overrun_q;
  logic [15:0]               stale_cnt;
  logic                      stale;

  assign shifted = $signed(bus.i_result_data) >>> SHIFT;

  // Rising-edge detect; the capture is registered together with its scaled sample,
  // so the FSM sees it one cycle later and o_cmd_valid rises two edges after capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_valid <= 1'b0;
      cap_q      <= 1'b0;
      sample_q   <= '0;
    end else begin
      prev_valid <= bus.i_result_valid;
      cap_q      <= bus.i_result_valid & ~prev_valid;
      if (bus.i_result_valid && !prev_valid) sample_q <= sat_steer(shifted);
    end
  end

  assign accept = cap_q && ((state == S_IDLE) || (state == S_PRESENT && bus.i_cmd_ready));
  assign drop   = cap_q && !accept;

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:    if (cap_q) state_nx = S_CALC;
      S_CALC:    state_nx = S_PRESENT;
      S_PRESENT: if (bus.i_cmd_ready) state_nx = cap_q ? S_CALC : S_IDLE;
      default:   state_nx = S_IDLE;
    endcase
  end

  lane_window_avg u_win (
    .clk   (clk),
    .rst   (rst),
    .wr_en (accept),
    .clear (bus.i_clear),
    .stale (stale),
    .din   (sample_q),
    .avg   (avg)
  );

  // Direction decision against the deadband.
  always_comb begin
    avg_ext = {{2{avg[STEER_W-1]}}, avg};
    dir_c   = STRAIGHT;
    if (avg_ext > DB)       dir_c = RIGHT;
    else if (avg_ext < -DB) dir_c = LEFT;
  end

  // Latch the command on entry to PRESENT so it holds while o_cmd_valid is high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      steer_q <= '0;
      dir_q   <= STRAIGHT;
    end else if (state == S_CALC) begin
      steer_q <= avg;
      dir_q   <= dir_c;
    end
  end

  // Sticky overrun; a new drop takes priority over a coincident clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)             overrun_q <= 1'b0;
    else if (drop)        overrun_q <= 1'b1;
    else if (bus.i_clear) overrun_q <= 1'b0;
  end

  // Watchdog: counts cycles since last capture, saturating at TIMEOUT.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                        stale_cnt <= '0;
    else if (cap_q)                  stale_cnt <= '0;
    else if (stale_cnt != TIMEOUT_C) stale_cnt <= stale_cnt + 16'd1;
  end

  assign stale           = (stale_cnt == TIMEOUT_C);
  assign bus.o_cmd_valid = (state == S_PRESENT);
  assign bus.o_steer     = steer_q;
  assign bus.o_dir       = dir_q;
  assign bus.o_overrun   = overrun_q;
  assign bus.o_stale     = stale;

endmodule

// File: tb/tb_lane_result_filter.sv
// Directed self-checking bench for lane_result_filter.
module tb_lane_result_filter;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  int   hs;

  lane_result_filter_if bus ();

  lane_result_filter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Rising edge on i_result_valid, then run to the point where o_cmd_valid should be up.
  task automatic capture(input logic [47:0] d, input string tag);
    bus.i_result_data  = d;
    bus.i_result_valid = 1'b1;
    tick();
    bus.i_result_valid = 1'b0;
    tick();
    check({tag, "_lat1"}, 48'(bus.o_cmd_valid), 48'd0);
    tick();
    check({tag, "_valid"}, 48'(bus.o_cmd_valid), 48'd1);
  endtask

  task automatic handshake();
    bus.i_cmd_ready = 1'b1;
    tick();
    bus.i_cmd_ready = 1'b0;
    check("hs_idle", 48'(bus.o_cmd_valid), 48'd0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b0;
    bus.i_result_valid = 1'b0;
    bus.i_result_data  = '0;
    bus.i_clear        = 1'b0;
    bus.i_cmd_ready    = 1'b0;
    tick();
    tick();
    check("rst_valid",   48'(bus.o_cmd_valid), 48'd0);
    check("rst_steer",   48'(bus.o_steer),     48'h0);
    check("rst_dir",     48'(bus.o_dir),       48'd0);
    check("rst_overrun", 48'(bus.o_overrun),   48'd0);
    check("rst_stale",   48'(bus.o_stale),     48'd0);
    rst = 1'b1;
    tick();

    // First capture preloads 300
    capture(48'h0000_012C_0000, "p300");
    check("p300_steer", 48'(bus.o_steer), 48'h012C);
    check("p300_dir",   48'(bus.o_dir),   48'd1);
    handshake();

    // -700 shifted in: 300*3-700 = 200, /4 = 50
    capture(48'hFFFF_FD44_0000, "m700");
    check("m700_steer", 48'(bus.o_steer), 48'h0032);
    check("m700_dir",   48'(bus.o_dir),   48'd0);
    handshake();

    // Positive saturation with fresh preload
    bus.i_clear = 1'b1; tick(); bus.i_clear = 1'b0;
    capture(48'h7FFF_FFFF_FFFF, "satp");
    check("satp_steer", 48'(bus.o_steer), 48'h7FFF);
    check("satp_dir",   48'(bus.o_dir),   48'd1);
    handshake();

    // Negative saturation with fresh preload
    bus.i_clear = 1'b1; tick(); bus.i_clear = 1'b0;
    capture(48'h8000_0000_0000, "satn");
    check("satn_steer", 48'(bus.o_steer), 48'h8000);
    check("satn_dir",   48'(bus.o_dir),   48'd2);
    handshake();

    // Level held 1000 cycles with ready high: exactly one handshake
    bus.i_clear = 1'b1; tick(); bus.i_clear = 1'b0;
    bus.i_result_data  = 48'h0000_03E8_0000;
    bus.i_result_valid = 1'b1;
    bus.i_cmd_ready    = 1'b1;
    hs = 0;
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (bus.o_cmd_valid && bus.i_cmd_ready) hs++;
    end
    check("hold_hs",    48'(hs),          48'd1);
    check("hold_steer", 48'(bus.o_steer), 48'h03E8);
    bus.i_result_valid = 1'b0;
    tick();
    bus.i_cmd_ready = 1'b0;

    // Overrun: second edge in PRESENT without ready
    capture(48'h0000_01F4_0000, "p500");
    check("p500_steer", 48'(bus.o_steer), 48'h036B);
    bus.i_result_data  = 48'h0000_07D0_0000;
    bus.i_result_valid = 1'b1;
    tick();
    bus.i_result_valid = 1'b0;
    tick();
    check("ovr_set",   48'(bus.o_overrun),   48'd1);
    check("ovr_steer", 48'(bus.o_steer),     48'h036B);
    check("ovr_valid", 48'(bus.o_cmd_valid), 48'd1);
    bus.i_clear = 1'b1; tick(); bus.i_clear = 1'b0;
    check("ovr_clear", 48'(bus.o_overrun), 48'd0);
    // Drop coinciding with clear: set wins
    bus.i_result_valid = 1'b1;
    tick();
    bus.i_result_valid = 1'b0;
    bus.i_clear = 1'b1;
    tick();
    bus.i_clear = 1'b0;
    check("ovr_setwins", 48'(bus.o_overrun), 48'd1);
    bus.i_clear = 1'b1; tick(); bus.i_clear = 1'b0;
    check("ovr_clear2", 48'(bus.o_overrun), 48'd0);
    handshake();

    // Fill window, then let the watchdog expire
    capture(48'h0000_0064_0000, "p100");
    check("p100_steer", 48'(bus.o_steer), 48'h0064);
    handshake();
    repeat (59997) tick();
    check("stale_early", 48'(bus.o_stale), 48'd0);
    tick();
    check("stale_set", 48'(bus.o_stale), 48'd1);
    capture(48'hFFFF_FE70_0000, "m400");
    check("m400_steer", 48'(bus.o_steer), 48'hFE70);
    check("m400_dir",   48'(bus.o_dir),   48'd2);
    check("m400_stale", 48'(bus.o_stale), 48'd0);
    handshake();

    // Reset while PRESENT discards the command
    capture(48'h0000_000A_0000, "prst");
    rst = 1'b0;
    #1;
    check("rstmid_valid", 48'(bus.o_cmd_valid), 48'd0);
    tick();
    rst = 1'b1;
    hs = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (bus.o_cmd_valid) hs++;
    end
    check("rstmid_novalid", 48'(hs),          48'd0);
    check("rstmid_steer",   48'(bus.o_steer), 48'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
